// File: rtl/cu_alloc_arbiter.sv
// Collector-unit allocator: round-robin choice of one issue slot per cycle, paired with
// the lowest free CU, holding the registered grant until the operand stage accepts it.

module cu_alloc_arbiter_chk #(
    parameter int NUM_CUS = 4
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_CUS-1:0] release_valid,
    input logic [NUM_CUS-1:0] cu_busy
);
    // A release aimed at an idle CU is dropped by the allocator; flag it so dispatch bugs surface.
    spurious_release_a: assert property (@(posedge clk) disable iff (!reset)
        (release_valid & ~cu_busy) == '0)
        else $warning("cu_alloc_arbiter: spurious release on idle CU, release=%b busy=%b",
                      release_valid, cu_busy);
endmodule

module cu_alloc_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int NUM_CUS  = 4,
    parameter int TAG_W    = 8,
    parameter int CTR_W    = 32,
    localparam int RQ_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CU_W    = (NUM_CUS > 1) ? $clog2(NUM_CUS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*TAG_W-1:0] req_tag,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      alloc_valid,
    output logic [CU_W-1:0]           alloc_cu,
    output logic [RQ_W-1:0]           alloc_req,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic                      alloc_ready,
    input  logic [NUM_CUS-1:0]        release_valid,
    output logic [NUM_CUS-1:0]        cu_busy,
    output logic [CTR_W-1:0]          stall_cnt
);
    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [NUM_CUS-1:0]  busy_q, busy_d;
    logic [RQ_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CTR_W-1:0]    stall_q, stall_d;
    logic [CU_W-1:0]     alloc_cu_q;
    logic [RQ_W-1:0]     alloc_req_q;
    logic [TAG_W-1:0]    alloc_tag_q;

    logic [NUM_CUS-1:0]  free_s;
    logic                out_open_s;
    logic                grant_s;
    logic [RQ_W-1:0]     winner_s;
    logic [CU_W-1:0]     cu_sel_s;

    // Issue condition: output slot free or draining, some CU free, some slot requesting.
    always_comb begin
        free_s     = ~busy_q;
        out_open_s = (state_q == EMPTY) | alloc_ready;
        grant_s    = reset & out_open_s & (|free_s) & (|req_valid);
    end

    // Round-robin scan from rr_ptr; iterating backwards lets the nearest valid slot win.
    always_comb begin
        int idx;
        idx      = 0;
        winner_s = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx      = int'(rr_ptr_q) + k;
            idx      = (idx >= NUM_REQS) ? (idx - NUM_REQS) : idx;
            winner_s = req_valid[idx] ? RQ_W'(idx) : winner_s;
        end
    end

    // Lowest-index free CU.
    always_comb begin
        cu_sel_s = '0;
        for (int c = NUM_CUS - 1; c >= 0; c--) begin
            cu_sel_s = free_s[c] ? CU_W'(c) : cu_sel_s;
        end
    end

    // Ready strobe for the winning slot only; never a function of the tag.
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Output FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = grant_s ? FULL : EMPTY;
            FULL:    state_d = alloc_ready ? (grant_s ? FULL : EMPTY) : FULL;
            default: state_d = EMPTY;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Busy flags, round-robin pointer and stall counter next state.
    always_comb begin
        busy_d   = busy_q & ~release_valid;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;
        if (grant_s) begin
            busy_d[cu_sel_s] = 1'b1;
            rr_ptr_d = (winner_s == RQ_W'(NUM_REQS - 1)) ? '0 : (winner_s + RQ_W'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if ((|req_valid) & ~(|free_s) & out_open_s) begin
            stall_d = stall_q + CTR_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Control state; releases seen during reset are discarded with everything else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    // Grant payload only loads on a grant, so it holds through backpressure.
    always_ff @(posedge clk) begin
        if (grant_s) begin
            alloc_cu_q  <= cu_sel_s;
            alloc_req_q <= winner_s;
            alloc_tag_q <= req_tag[int'(winner_s)*TAG_W +: TAG_W];
        end
    end

    // Output drive.
    always_comb begin
        alloc_valid = (state_q == FULL);
        alloc_cu    = alloc_cu_q;
        alloc_req   = alloc_req_q;
        alloc_tag   = alloc_tag_q;
        cu_busy     = busy_q;
        stall_cnt   = stall_q;
    end

    cu_alloc_arbiter_chk #(.NUM_CUS(NUM_CUS)) u_chk (
        .clk          (clk),
        .reset        (reset),
        .release_valid(release_valid),
        .cu_busy      (busy_q)
    );
endmodule

// File: tb/tb_cu_alloc_arbiter.sv
// Self-checking bench for cu_alloc_arbiter: behavioural model plus a grant scoreboard,
// directed scenarios followed by constrained-random traffic.

module tb_cu_alloc_arbiter;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int TW = 8;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*TW-1:0] req_tag;
    logic [NR-1:0]    req_ready;
    logic             alloc_valid;
    logic [1:0]       alloc_cu;
    logic [1:0]       alloc_req;
    logic [TW-1:0]    alloc_tag;
    logic             alloc_ready;
    logic [NC-1:0]    release_valid;
    logic [NC-1:0]    cu_busy;
    logic [CW-1:0]    stall_cnt;

    always #5 clk = ~clk;

    cu_alloc_arbiter #(.NUM_REQS(NR), .NUM_CUS(NC), .TAG_W(TW), .CTR_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .alloc_valid  (alloc_valid),
        .alloc_cu     (alloc_cu),
        .alloc_req    (alloc_req),
        .alloc_tag    (alloc_tag),
        .alloc_ready  (alloc_ready),
        .release_valid(release_valid),
        .cu_busy      (cu_busy),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        int         cu;
        int         slot;
        logic [7:0] tag;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [3:0]  m_busy = 4'b0000;
    logic        m_av = 1'b0;
    int          m_ptr = 0;
    logic [31:0] m_stall = 32'd0;
    logic [3:0]  obs_ready;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, check combinational ready, advance the model, check registered state.
    task automatic run_cycle(input logic [3:0] rv, input logic [31:0] tags, input logic ar,
                             input logic [3:0] rel, input logic rst);
        logic [3:0] free;
        logic [3:0] exp_ready;
        logic       ok;
        logic       grant;
        int         w;
        int         c;
        exp_t       e;
        @(negedge clk);
        reset = rst; req_valid = rv; req_tag = tags; alloc_ready = ar; release_valid = rel;
        #1;
        obs_ready = req_ready;
        grant = 1'b0; exp_ready = 4'b0000; w = 0; c = 0;
        free = ~m_busy;
        ok = !m_av || ar;
        if (!rst) begin
            check_val("ready_in_reset", 32'(req_ready), 32'd0);
            m_busy = 4'b0000; m_av = 1'b0; m_ptr = 0; m_stall = 32'd0;
            sb.delete();
        end else begin
            if (m_av && ar) begin
                if (sb.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
                else void'(sb.pop_front());
            end
            if (ok && free != 4'b0000 && rv != 4'b0000) begin
                grant = 1'b1;
                w = m_ptr;
                while (!rv[w]) w = (w + 1) % NR;
                while (!free[c]) c++;
                exp_ready[w] = 1'b1;
            end
            check_val("req_ready", 32'(req_ready), 32'(exp_ready));
            if (rv != 4'b0000 && free == 4'b0000 && ok) m_stall = m_stall + 32'd1;
            m_busy = (m_busy & ~rel) | (grant ? (4'b0001 << c) : 4'b0000);
            if (grant) begin
                m_av = 1'b1;
                m_ptr = (w + 1) % NR;
                e.cu = c; e.slot = w; e.tag = tags[w*TW +: TW];
                sb.push_back(e);
            end else if (ar) begin
                m_av = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_val("alloc_valid", 32'(alloc_valid), 32'(m_av));
        check_val("cu_busy", 32'(cu_busy), 32'(m_busy));
        check_val("stall_cnt", stall_cnt, m_stall);
        if (m_av) begin
            if (sb.size() == 0) begin
                check_val("sb_empty", 32'd1, 32'd0);
            end else begin
                check_val("alloc_cu", 32'(alloc_cu), 32'(sb[0].cu));
                check_val("alloc_req", 32'(alloc_req), 32'(sb[0].slot));
                check_val("alloc_tag", 32'(alloc_tag), 32'(sb[0].tag));
            end
        end
    endtask

    localparam logic [31:0] TAGS = 32'hD4C3B2A1;

    initial begin
        reset = 1'b0; req_valid = '0; req_tag = '0; alloc_ready = 1'b0; release_valid = '0;

        run_cycle(4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0);
        run_cycle(4'b0000, 32'd0, 1'b1, 4'b1111, 1'b0);
        check_val("rst_busy", 32'(cu_busy), 32'd0);
        check_val("rst_av", 32'(alloc_valid), 32'd0);
        check_val("rst_stall", stall_cnt, 32'd0);

        // single grant
        run_cycle(4'b0001, 32'h0000005A, 1'b1, 4'b0000, 1'b1);
        check_val("single_ready", 32'(obs_ready), 32'h1);
        check_val("single_av", 32'(alloc_valid), 32'd1);
        check_val("single_cu", 32'(alloc_cu), 32'd0);
        check_val("single_req", 32'(alloc_req), 32'd0);
        check_val("single_tag", 32'(alloc_tag), 32'h5A);
        check_val("single_busy", 32'(cu_busy), 32'h1);
        run_cycle(4'b0000, 32'd0, 1'b1, 4'b0001, 1'b1);
        check_val("rel0_busy", 32'(cu_busy), 32'd0);
        run_cycle(4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0);

        // round robin fills all CUs then stalls
        for (int i = 0; i < 4; i++) begin
            run_cycle(4'b1111, TAGS, 1'b1, 4'b0000, 1'b1);
            check_val("rr_ready", 32'(obs_ready), 32'(4'b0001 << i));
            check_val("rr_cu", 32'(alloc_cu), 32'(i));
            check_val("rr_req", 32'(alloc_req), 32'(i));
        end
        for (int i = 1; i <= 2; i++) begin
            run_cycle(4'b1111, TAGS, 1'b1, 4'b0000, 1'b1);
            check_val("rr_stall", stall_cnt, 32'(i));
        end

        // release of CU2 lets a waiting request through one cycle later
        run_cycle(4'b1111, TAGS, 1'b1, 4'b0100, 1'b1);
        check_val("rel_ready_n", 32'(obs_ready), 32'd0);
        check_val("rel_busy", 32'(cu_busy), 32'hB);
        run_cycle(4'b1111, TAGS, 1'b1, 4'b0000, 1'b1);
        check_val("rel_ready_n1", 32'(obs_ready), 32'h1);
        check_val("rel_cu", 32'(alloc_cu), 32'd2);

        // backpressure: free CU present, but output held
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b0010, TAGS, 1'b0, (i == 0) ? 4'b0010 : 4'b0000, 1'b1);
            check_val("bp_ready", 32'(obs_ready), 32'd0);
            check_val("bp_cu", 32'(alloc_cu), 32'd2);
            check_val("bp_req", 32'(alloc_req), 32'd0);
            check_val("bp_tag", 32'(alloc_tag), 32'hA1);
            check_val("bp_stall", stall_cnt, 32'd3);
        end
        run_cycle(4'b0010, TAGS, 1'b1, 4'b0000, 1'b1);
        check_val("bp_grant_cu", 32'(alloc_cu), 32'd1);

        // mid-operation reset with busy=1011 and a pending grant
        run_cycle(4'b0000, 32'd0, 1'b0, 4'b0100, 1'b1);
        check_val("pre_rst_busy", 32'(cu_busy), 32'hB);
        run_cycle(4'b0000, 32'd0, 1'b1, 4'b1000, 1'b0);
        check_val("mid_rst_busy", 32'(cu_busy), 32'd0);
        check_val("mid_rst_av", 32'(alloc_valid), 32'd0);
        check_val("mid_rst_stall", stall_cnt, 32'd0);
        run_cycle(4'b1111, TAGS, 1'b1, 4'b0000, 1'b1);
        check_val("post_rst_ready", 32'(obs_ready), 32'h1);

        // spurious release of idle CU3
        run_cycle(4'b0000, 32'd0, 1'b1, 4'b1000, 1'b1);
        check_val("spur_busy", 32'(cu_busy), 32'h1);

        for (int i = 0; i < 400; i++) begin
            run_cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0),
                      4'($urandom) & m_busy, ($urandom_range(0, 59) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cu_alloc_arbiter.md
CU_ALLOC_ARBITER -- requirements
Module: cu_alloc_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQS, default 4: number of issue slots requesting a collector unit (CU).
REQ-002 SHALL take parameter NUM_CUS, default 4: number of CUs managed.
REQ-003 SHALL take parameter TAG_W, default 8: width of the per-request tag (uuid/wid payload).
REQ-004 SHALL take parameter CTR_W, default 32: width of the stall counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQS bits: per-slot request.
REQ-008 SHALL have port req_tag, input, NUM_REQS*TAG_W bits: per-slot tag; slot i occupies bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port req_ready, output, NUM_REQS bits: one-hot or zero; it marks the accepted slot.
REQ-010 SHALL have port alloc_valid, output, 1 bit: a registered grant is pending.
REQ-011 SHALL have port alloc_cu, output, CLOG2(NUM_CUS) bits: the granted CU index.
REQ-012 SHALL have port alloc_req, output, CLOG2(NUM_REQS) bits: the granted slot index.
REQ-013 SHALL have port alloc_tag, output, TAG_W bits: the tag of the granted slot.
REQ-014 SHALL have port alloc_ready, input, 1 bit: the operand stage accepts the grant.
REQ-015 SHALL have port release_valid, input, NUM_CUS bits: per-CU release pulse from dispatch.
REQ-016 SHALL have port cu_busy, output, NUM_CUS bits: per-CU allocated flag.
REQ-017 SHALL have port stall_cnt, output, CTR_W bits: count of cycles stalled for lack of a free CU.

Function
REQ-018 SHALL define free[c] = ~cu_busy[c]; a CU is busy from the cycle after its grant until the cycle after its release.
REQ-019 SHALL define can_issue = (~alloc_valid | alloc_ready) & (|free) & (|req_valid).
REQ-020 SHALL, when can_issue, select the winner as the first valid slot scanning rr_ptr, rr_ptr+1, ... mod NUM_REQS, and drive req_ready for the winner only.
REQ-021 SHALL, when can_issue, select the lowest-index free CU.
REQ-022 SHALL make req_ready depend combinationally on req_valid, rr_ptr, cu_busy, alloc_valid and alloc_ready, and never on req_tag.
REQ-023 SHALL, on a grant at cycle N, in cycle N+1: set alloc_valid=1, alloc_cu=CU, alloc_req=winner, alloc_tag=tag, cu_busy[CU]=1, rr_ptr=(winner+1) mod NUM_REQS.
REQ-024 SHALL implement an output FSM with states EMPTY and FULL:
- EMPTY->FULL on grant.
- FULL stays FULL on alloc_ready together with a new grant.
- FULL->EMPTY on alloc_ready without a grant.
- FULL holds on ~alloc_ready.
REQ-025 SHALL hold alloc_* stable while alloc_valid=1 and alloc_ready=0.
REQ-026 SHALL, on release_valid[c]=1, clear cu_busy[c] in the next cycle; the CU becomes grantable one cycle after the release (no same-cycle bypass).
REQ-027 SHALL ignore release_valid[c] for a CU that is not busy, with no state change; a simulation assertion SHALL flag it.
REQ-028 SHALL apply simultaneous releases of multiple CUs, together with a grant of a different CU, all in the same cycle.
REQ-029 SHALL leave rr_ptr unchanged in any cycle without a grant.
REQ-030 SHALL increment stall_cnt by 1 in each cycle where (|req_valid) & ~(|free) & (~alloc_valid | alloc_ready); it wraps modulo 2^CTR_W.
REQ-031 SHALL not count backpressure cycles (alloc_valid & ~alloc_ready) as stalls.

Reset
REQ-032 SHALL, in any cycle where reset=0, clear alloc_valid, cu_busy, rr_ptr and stall_cnt, and force req_ready=0.
REQ-033 SHALL drop a pending grant and all busy flags on reset mid-operation; releases arriving during reset are ignored.
REQ-034 SHALL leave alloc_cu, alloc_req and alloc_tag with no defined reset value; they are don't-care while alloc_valid=0.

Verification
REQ-035 SHALL cover the single grant: req_valid=0001, tag 0x5A, alloc_ready=1 -> req_ready=0001 at cycle N; at N+1 alloc_valid=1, alloc_cu=0, alloc_req=0, alloc_tag=0x5A, cu_busy=0001.
REQ-036 SHALL cover round-robin: req_valid=1111 held, alloc_ready=1, NUM_CUS=4 -> grants go to slots 0,1,2,3 on CUs 0,1,2,3 over 4 cycles, then stall_cnt increments by 1 per cycle.
REQ-037 SHALL cover release: all CUs busy, release_valid=0100 at cycle N -> cu_busy[2]=0 at N+1; a waiting request gets req_ready at N+1 and alloc_cu=2 at N+2.
REQ-038 SHALL cover backpressure: alloc_valid=1, alloc_ready=0 for 3 cycles with req_valid=0010 -> alloc_* unchanged, req_ready=0, stall_cnt unchanged.
REQ-039 SHALL cover mid-operation reset: reset=0 for 1 cycle with cu_busy=1011 and alloc_valid=1 -> next cycle cu_busy=0000, alloc_valid=0, stall_cnt=0, rr_ptr=0.
REQ-040 SHALL cover a spurious release: release_valid=1000 with cu_busy[3]=0 -> cu_busy unchanged and the assertion fires.
